// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding for the pipeline stage.
package pipe_pkg;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;
    typedef enum logic [1:0] {EMPTY = OCC_EMPTY, ONE = OCC_ONE, TWO = OCC_TWO} stage_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, cleared synchronously.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    always_ff @(posedge clk) begin
        cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
    end
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline stage with optional skid entry, flush/hold
// and saturating stall/flush counters.
module pipe_stage import pipe_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int SKID       = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  flush_i,
    input  logic                  hold_i,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);
    stage_state_t          r_state, w_next;
    logic [DATA_WIDTH-1:0] r_main, w_main_next, w_skid;
    logic                  w_rdy, w_active, w_in, w_out;

    assign w_active = !rst && !flush_i && !hold_i;
    assign w_in     = in_valid_i && in_ready_o;
    assign w_out    = out_valid_o && out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
        end else begin
            r_state <= w_next;
            r_main  <= w_main_next;
        end
    end

    always_comb begin
        w_next = flush_i ? EMPTY
               : (r_state == EMPTY) ? (w_in ? ONE : EMPTY)
               : (r_state == ONE) ? ((w_in && !w_out && SKID != 0) ? TWO : (!w_in && w_out) ? EMPTY : ONE)
               : (w_out ? ONE : TWO);
        w_main_next = (flush_i || w_next == EMPTY) ? '0
                    : (r_state == TWO && w_out) ? w_skid
                    : (w_in && (r_state == EMPTY || w_out)) ? in_data_i
                    : r_main;
    end

    always_comb begin
        in_ready_o  = w_active && w_rdy;
        out_valid_o = w_active && (r_state != EMPTY);
        out_data_o  = (rst || r_state == EMPTY) ? '0 : r_main;
    end

    // Skid variant registers ready so upstream never sees out_ready_i combinationally.
    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_WIDTH-1:0] r_skid;
            logic                  r_rdy;
            always_ff @(posedge clk) begin
                if (rst || flush_i) r_skid <= '0;
                else if (r_state == ONE && w_next == TWO) r_skid <= in_data_i;
                else if (r_state == TWO && w_out) r_skid <= '0;
                r_rdy <= rst || (w_next != TWO);
            end
            assign w_skid = r_skid;
            assign w_rdy  = r_rdy;
        end else begin : g_noskid
            assign w_skid = '0;
            assign w_rdy  = (r_state == EMPTY) || out_ready_i;
        end
    endgenerate

    assign occupancy_o = r_state;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (out_valid_o && !out_ready_i),
        .cnt (stall_cnt_o)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (flush_i && r_state != EMPTY),
        .cnt (flush_cnt_o)
    );
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed checks of a skid stage (a) and a single-entry
// stage with 4-bit counters (b).
module tb_pipe_stage;
    logic        clk = 0;
    logic        rst = 1;
    logic        a_iv = 0, a_ir, a_ov, a_or = 0, a_fl = 0, a_ho = 0;
    logic [31:0] a_id = 0, a_od;
    logic [1:0]  a_occ;
    logic [15:0] a_sc, a_fc;
    logic        b_iv = 0, b_ir, b_ov, b_or = 0, b_fl = 0, b_ho = 0;
    logic [7:0]  b_id = 0, b_od;
    logic [1:0]  b_occ;
    logic [3:0]  b_sc, b_fc;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    pipe_stage #(.DATA_WIDTH(32), .SKID(1), .CNT_WIDTH(16)) u_a (
        .clk(clk), .rst(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(a_id),
        .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od), .flush_i(a_fl),
        .hold_i(a_ho), .occupancy_o(a_occ), .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
    );

    pipe_stage #(.DATA_WIDTH(8), .SKID(0), .CNT_WIDTH(4)) u_b (
        .clk(clk), .rst(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(b_id),
        .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od), .flush_i(b_fl),
        .hold_i(b_ho), .occupancy_o(b_occ), .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ir", a_ir, 0);
        chk("rst_ov", a_ov, 0);
        chk("rst_od", a_od, 0);
        rst = 0;
        settle();
        chk("post_rst_ir", a_ir, 1);
        chk("post_rst_occ", a_occ, 0);
        chk("post_rst_sc", a_sc, 0);
        chk("post_rst_fc", a_fc, 0);
        // streaming at full rate
        a_or = 1;
        for (int i = 1; i <= 8; i++) begin
            a_iv = 1;
            a_id = i;
            settle();
            chk("strm_ir", a_ir, 1);
            tick();
            chk("strm_ov", a_ov, 1);
            chk("strm_od", a_od, i);
            chk("strm_occ", a_occ, 1);
        end
        a_iv = 0;
        settle();
        tick();
        chk("strm_end_ov", a_ov, 0);
        chk("strm_end_od", a_od, 0);
        chk("strm_end_occ", a_occ, 0);
        chk("strm_sc", a_sc, 0);
        // skid fill under back-pressure
        a_or = 0;
        a_iv = 1;
        a_id = 32'hA;
        settle();
        chk("skid_ir_a", a_ir, 1);
        tick();
        chk("skid_od_a", a_od, 32'hA);
        a_id = 32'hB;
        settle();
        chk("skid_ir_b", a_ir, 1);
        tick();
        chk("skid_occ2", a_occ, 2);
        chk("skid_sc1", a_sc, 1);
        a_id = 32'hC;
        settle();
        chk("skid_ir_c", a_ir, 0);
        tick();
        chk("skid_hold_od", a_od, 32'hA);
        chk("skid_hold_occ", a_occ, 2);
        a_or = 1;
        settle();
        chk("skid_sc2", a_sc, 2);
        chk("skid_ir_reg", a_ir, 0);
        tick();
        chk("skid_drain_b", a_od, 32'hB);
        chk("skid_ir_back", a_ir, 1);
        tick();
        chk("skid_drain_c", a_od, 32'hC);
        chk("skid_drain_occ", a_occ, 1);
        a_iv = 0;
        settle();
        tick();
        chk("skid_empty", a_occ, 0);
        chk("skid_sc_final", a_sc, 2);
        // flush with two entries held
        a_or = 0;
        a_iv = 1;
        a_id = 32'h11;
        settle();
        tick();
        a_id = 32'h22;
        settle();
        tick();
        chk("fl_occ2", a_occ, 2);
        a_fl = 1;
        a_id = 32'h33;
        settle();
        chk("fl_ir", a_ir, 0);
        chk("fl_ov", a_ov, 0);
        tick();
        a_fl = 0;
        a_iv = 0;
        settle();
        chk("fl_occ0", a_occ, 0);
        chk("fl_ov_after", a_ov, 0);
        chk("fl_od_after", a_od, 0);
        chk("fl_cnt1", a_fc, 1);
        a_fl = 1;
        settle();
        tick();
        a_fl = 0;
        chk("fl_empty_cnt", a_fc, 1);
        chk("fl_sc", a_sc, 3);
        // hold with one entry
        a_iv = 1;
        a_id = 32'h55;
        settle();
        tick();
        a_iv = 0;
        a_ho = 1;
        settle();
        chk("ho_ov", a_ov, 0);
        chk("ho_ir", a_ir, 0);
        tick();
        tick();
        tick();
        chk("ho_sc", a_sc, 3);
        chk("ho_occ", a_occ, 1);
        a_ho = 0;
        settle();
        chk("ho_rel_ov", a_ov, 1);
        chk("ho_rel_od", a_od, 32'h55);
        a_or = 1;
        settle();
        tick();
        chk("ho_drain_occ", a_occ, 0);
        // reset mid-transfer
        a_or = 0;
        a_iv = 1;
        a_id = 32'h77;
        settle();
        tick();
        a_iv = 0;
        rst = 1;
        settle();
        chk("mid_rst_ov", a_ov, 0);
        chk("mid_rst_od", a_od, 0);
        chk("mid_rst_ir", a_ir, 0);
        tick();
        rst = 0;
        settle();
        chk("mid_rst_occ", a_occ, 0);
        chk("mid_rst_fc", a_fc, 0);
        chk("mid_rst_ir1", a_ir, 1);
        // single-entry stage: combinational ready and replace
        b_iv = 1;
        b_id = 8'h5A;
        settle();
        chk("b_ir_empty", b_ir, 1);
        tick();
        chk("b_od_5a", b_od, 8'h5A);
        b_id = 8'h6B;
        settle();
        chk("b_ir_blocked", b_ir, 0);
        b_or = 1;
        settle();
        chk("b_ir_comb", b_ir, 1);
        tick();
        chk("b_od_6b", b_od, 8'h6B);
        chk("b_occ1", b_occ, 1);
        chk("b_sc0", b_sc, 0);
        // saturation of the 4-bit stall counter
        b_iv = 0;
        b_or = 0;
        settle();
        for (int i = 0; i < 10; i++) tick();
        chk("b_sc10", b_sc, 10);
        for (int i = 0; i < 10; i++) tick();
        chk("b_sc_sat", b_sc, 15);
        tick();
        tick();
        chk("b_sc_stay", b_sc, 15);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
